// File: rtl/trigger_pkg.sv
// Shared types and default sizing for the trigger sequencer slice.
// The post-trigger delay feature is enabled by defining TRIGGER_SEQUENCER_DLY_EN.
package trigger_pkg;

  // Default sizing. Modules take these as parameter defaults and derive
  // their own index widths from whatever they are given.
  localparam int NS_DEF = 4;
  localparam int NE_DEF = 4;
  localparam int CW_DEF = 16;

  // Stage-index and event-index widths for the default sizing.
  localparam int SW_DEF = $clog2(NS_DEF);
  localparam int EW_DEF = $clog2(NE_DEF);

  // Sequencer states. DELAY is never entered when the delay feature is
  // compiled out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    DONE  = 2'd3
  } trg_state_e;

endpackage

// File: rtl/trigger_sequencer_if.sv
// Control, configuration, stimulus and status bundle of the trigger sequencer.
// The master side (capture control / bench) drives ctl_*, cfg_* and sti_*;
// the slave side (the sequencer) returns sts_*.
interface trigger_sequencer_if
  import trigger_pkg::*;
#(
  parameter int NS = NS_DEF,
  parameter int NE = NE_DEF,
  parameter int CW = CW_DEF
);
  localparam int SW = $clog2(NS);
  localparam int EW = $clog2(NE);

  logic             ctl_arm;
  logic             ctl_abort;
  logic [NS*EW-1:0] cfg_sel;
  logic [NS*CW-1:0] cfg_cnt;
  logic [SW-1:0]    cfg_lst;
  logic [CW-1:0]    cfg_dly;
  logic             sti_transfer;
  logic [NE-1:0]    sti_evt;
  logic             sts_armed;
  logic [SW-1:0]    sts_stage;
  logic             sts_trg;
  logic             sts_done;

  modport master (
    output ctl_arm, ctl_abort, cfg_sel, cfg_cnt, cfg_lst, cfg_dly,
    output sti_transfer, sti_evt,
    input  sts_armed, sts_stage, sts_trg, sts_done
  );

  modport slave (
    input  ctl_arm, ctl_abort, cfg_sel, cfg_cnt, cfg_lst, cfg_dly,
    input  sti_transfer, sti_evt,
    output sts_armed, sts_stage, sts_trg, sts_done
  );

endinterface

// File: rtl/trigger_counter.sv
// Shared hit/delay counter: clear has priority over enable, and eq reports
// whether the current count equals the compare value selected by the owner.
module trigger_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] cmp,
  output logic          eq
);

  logic [CW-1:0] cnt_q;

  // Count register: clear wins, otherwise increment when enabled.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign eq = (cnt_q == cmp);

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer: each stage waits for its selected matcher
// event to hit cnt+1 times, the last stage optionally waits dly transfers,
// then a one-cycle trigger pulse is issued.
// Optional feature macro: TRIGGER_SEQUENCER_DLY_EN (post-trigger delay).
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int NS = NS_DEF,
  parameter int NE = NE_DEF,
  parameter int CW = CW_DEF
) (
  input logic               clk,
  input logic               rst,
  trigger_sequencer_if.slave bus
);

  localparam int SW = $clog2(NS);
  localparam int EW = $clog2(NE);

  trg_state_e    state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          armed_q, armed_d;
  logic          trg_q, trg_d;
  logic          done_q, done_d;

  // Latched configuration
  logic [EW-1:0] sel_q [NS];
  logic [CW-1:0] cnt_q [NS];
  logic [SW-1:0] lst_q;
  logic          load_cfg;

  // Counter control
  logic          ctr_clr;
  logic          ctr_en;
  logic [CW-1:0] ctr_cmp;
  logic          ctr_eq;

  logic          hit;
  logic          fire;
  logic          dly_zero;

  assign hit = bus.sti_transfer && bus.sti_evt[sel_q[stage_q]];

`ifdef TRIGGER_SEQUENCER_DLY_EN
  logic [CW-1:0] dly_q;

  // Delay length latch, written only on the arm cycle.
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      dly_q <= bus.cfg_dly;
    end
  end

  assign dly_zero = (dly_q == '0);
  // In DELAY the counter holds completed transfers; the dly-th one fires.
  assign ctr_cmp  = (state_q == DELAY) ? (dly_q - CW'(1)) : cnt_q[stage_q];
`else
  assign dly_zero = 1'b1;
  assign ctr_cmp  = cnt_q[stage_q];
`endif

  // Per-stage configuration latch, written only on the arm cycle.
  // NOTE: config registers carry no reset; they are always loaded by ctl_arm
  // before any state that reads them can be reached.
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      for (int k = 0; k < NS; k++) begin
        sel_q[k] <= bus.cfg_sel[k*EW +: EW];
        cnt_q[k] <= bus.cfg_cnt[k*CW +: CW];
      end
      lst_q <= bus.cfg_lst;
    end
  end

  // Single counter shared between hit counting (ARMED) and delay counting (DELAY).
  trigger_counter #(.CW(CW)) u_counter (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .cmp (ctr_cmp),
    .eq  (ctr_eq)
  );

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      armed_q <= 1'b0;
      trg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      armed_q <= armed_d;
      trg_q   <= trg_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: abort beats arm, arm restarts from any state, then
  // per-state hit / delay handling.
  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    load_cfg = 1'b0;
    fire     = 1'b0;
    if (bus.ctl_abort) begin
      state_d = IDLE;
      stage_d = '0;
      ctr_clr = 1'b1;
    end else if (bus.ctl_arm) begin
      state_d  = ARMED;
      stage_d  = '0;
      ctr_clr  = 1'b1;
      load_cfg = 1'b1;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (hit) begin
            if (ctr_eq) begin
              ctr_clr = 1'b1;
              if (stage_q != lst_q) begin
                stage_d = stage_q + SW'(1);
              end else if (dly_zero) begin
                fire    = 1'b1;
                state_d = DONE;
              end else begin
                state_d = DELAY;
              end
            end else begin
              ctr_en = 1'b1;
            end
          end
        end
`ifdef TRIGGER_SEQUENCER_DLY_EN
        DELAY: begin
          if (bus.sti_transfer) begin
            if (ctr_eq) begin
              ctr_clr = 1'b1;
              fire    = 1'b1;
              state_d = DONE;
            end else begin
              ctr_en = 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Output decode of the next state, registered above so status is glitch-free.
  always_comb begin
    armed_d = (state_d == ARMED) || (state_d == DELAY);
    done_d  = (state_d == DONE);
    trg_d   = fire;
  end

  assign bus.sts_armed = armed_q;
  assign bus.sts_stage = stage_q;
  assign bus.sts_trg   = trg_q;
  assign bus.sts_done  = done_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of the sequencing rules.
module tb_trigger_sequencer;

  localparam int NS = 4;
  localparam int NE = 4;
  localparam int CW = 16;
  localparam int SW = 2;
  localparam int EW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  trigger_sequencer_if #(.NS(NS), .NE(NE), .CW(CW)) bus ();

  trigger_sequencer #(.NS(NS), .NE(NE), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- configuration helpers ----------------
  int t_sel [NS];
  int t_cnt [NS];
  int t_lst;
  int t_dly;

  task automatic apply_cfg();
    for (int k = 0; k < NS; k++) begin
      bus.cfg_sel[k*EW +: EW] = EW'(t_sel[k]);
      bus.cfg_cnt[k*CW +: CW] = CW'(t_cnt[k]);
    end
    bus.cfg_lst = SW'(t_lst);
    bus.cfg_dly = CW'(t_dly);
  endtask

  // Drive one cycle of inputs at the falling edge; return just after the
  // rising edge that consumes them.
  task automatic cycle(input bit arm, input bit abort, input bit xfer, input logic [NE-1:0] evt);
    @(negedge clk);
    bus.ctl_arm      = arm;
    bus.ctl_abort    = abort;
    bus.sti_transfer = xfer;
    bus.sti_evt      = evt;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0 idle, 1 collecting hits, 2 counting delay transfers, 3 done
  int     m_phase;
  int     m_sel  [NS];
  longint m_need [NS];
  int     m_lst;
  longint m_dly;
  int     m_stage;
  longint m_hits;
  longint m_xfers;
  bit     e_trg;
  bit     chk_on = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      m_stage = 0;
      m_hits  = 0;
      m_xfers = 0;
      e_trg   = 1'b0;
    end else begin
      e_trg = 1'b0;
      if (bus.ctl_abort) begin
        m_phase = 0;
        m_stage = 0;
      end else if (bus.ctl_arm) begin
        for (int k = 0; k < NS; k++) begin
          m_sel[k]  = int'(bus.cfg_sel[k*EW +: EW]);
          m_need[k] = longint'(bus.cfg_cnt[k*CW +: CW]) + 1;
        end
        m_lst = int'(bus.cfg_lst);
`ifdef TRIGGER_SEQUENCER_DLY_EN
        m_dly = longint'(bus.cfg_dly);
`else
        m_dly = 0;
`endif
        m_phase = 1;
        m_stage = 0;
        m_hits  = 0;
      end else if (m_phase == 1 && bus.sti_transfer && bus.sti_evt[m_sel[m_stage]]) begin
        m_hits++;
        if (m_hits == m_need[m_stage]) begin
          if (m_stage < m_lst) begin
            m_stage++;
            m_hits = 0;
          end else if (m_dly == 0) begin
            e_trg   = 1'b1;
            m_phase = 3;
          end else begin
            m_phase = 2;
            m_xfers = 0;
          end
        end
      end else if (m_phase == 2 && bus.sti_transfer) begin
        m_xfers++;
        if (m_xfers == m_dly) begin
          e_trg   = 1'b1;
          m_phase = 3;
        end
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("mdl_armed", int'(bus.sts_armed), int'(m_phase == 1 || m_phase == 2));
      check("mdl_stage", int'(bus.sts_stage), m_stage);
      check("mdl_trg",   int'(bus.sts_trg),   int'(e_trg));
      check("mdl_done",  int'(bus.sts_done),  int'(m_phase == 3));
    end
  end

  typedef struct {
    bit             xfer;
    logic [NE-1:0]  evt;
    int             stage;
    int             trg;
  } step_t;

  step_t s2 [11] = '{
    '{1'b0, 4'b1111, 0, 0},   // event high, no transfer
    '{1'b1, 4'b0001, 0, 0},   // miss
    '{1'b1, 4'b0010, 1, 0},   // stage 0 hit -> 1
    '{1'b1, 4'b1000, 1, 0},
    '{1'b1, 4'b1000, 1, 0},
    '{1'b0, 4'b1000, 1, 0},   // no transfer
    '{1'b1, 4'b0010, 1, 0},   // miss
    '{1'b1, 4'b1000, 1, 0},
    '{1'b1, 4'b1000, 2, 0},   // 4th hit -> 2
    '{1'b1, 4'b0001, 2, 0},
    '{1'b1, 4'b0001, 2, 1}    // 2nd hit -> trigger
  };

  initial begin
    bus.ctl_arm      = 1'b0;
    bus.ctl_abort    = 1'b0;
    bus.sti_transfer = 1'b0;
    bus.sti_evt      = '0;
    for (int k = 0; k < NS; k++) begin
      t_sel[k] = 0;
      t_cnt[k] = 0;
    end
    t_lst = 0;
    t_dly = 0;
    apply_cfg();

    // Reset state
    #1;
    check("rst_armed", int'(bus.sts_armed), 0);
    check("rst_stage", int'(bus.sts_stage), 0);
    check("rst_trg",   int'(bus.sts_trg),   0);
    check("rst_done",  int'(bus.sts_done),  0);
    @(negedge clk);
    rst    = 1'b1;
    chk_on = 1'b1;

    // Scenario 1: single stage, immediate trigger
    t_lst = 0; t_sel[0] = 2; t_cnt[0] = 0; t_dly = 0;
    apply_cfg();
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    check("s1_armed", int'(bus.sts_armed), 1);
    cycle(1'b0, 1'b0, 1'b1, 4'b0100);
    check("s1_trg",   int'(bus.sts_trg),   1);
    check("s1_done",  int'(bus.sts_done),  1);
    check("s1_armed2", int'(bus.sts_armed), 0);
    cycle(1'b0, 1'b0, 1'b0, 4'b0000);
    check("s1_trg_end", int'(bus.sts_trg), 0);

    // Scenario 2: three stages, mixed misses and hits
    t_lst = 2; t_sel[0] = 1; t_sel[1] = 3; t_sel[2] = 0;
    t_cnt[0] = 0; t_cnt[1] = 3; t_cnt[2] = 1;
    apply_cfg();
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    check("s2_arm_stage", int'(bus.sts_stage), 0);
    for (int i = 0; i < 11; i++) begin
      cycle(1'b0, 1'b0, s2[i].xfer, s2[i].evt);
      check($sformatf("s2_stage%0d", i), int'(bus.sts_stage), s2[i].stage);
      check($sformatf("s2_trg%0d", i),   int'(bus.sts_trg),   s2[i].trg);
    end
    check("s2_done", int'(bus.sts_done), 1);

    // Scenario 3: post-trigger delay of 5 with gapped transfers
    t_lst = 0; t_sel[0] = 2; t_cnt[0] = 0; t_dly = 5;
    apply_cfg();
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b1, 4'b0100);
`ifdef TRIGGER_SEQUENCER_DLY_EN
    check("s3_hit_trg",   int'(bus.sts_trg),   0);
    check("s3_hit_armed", int'(bus.sts_armed), 1);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'b0100);
      check($sformatf("s3_gap%0d", k), int'(bus.sts_trg), 0);
      cycle(1'b0, 1'b0, 1'b1, 4'b0000);
      check($sformatf("s3_xfer%0d", k), int'(bus.sts_trg), int'(k == 5));
    end
`else
    check("s3_hit_trg",  int'(bus.sts_trg),  1);
    check("s3_hit_done", int'(bus.sts_done), 1);
`endif

    // Scenario 4: abort mid stage 1, then arm+abort together
    t_lst = 2; t_sel[0] = 1; t_sel[1] = 3; t_sel[2] = 0;
    t_cnt[0] = 0; t_cnt[1] = 3; t_cnt[2] = 1; t_dly = 0;
    apply_cfg();
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b1, 4'b0010);
    check("s4_stage1", int'(bus.sts_stage), 1);
    cycle(1'b0, 1'b0, 1'b1, 4'b1000);
    cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    check("s4_abort_armed", int'(bus.sts_armed), 0);
    check("s4_abort_stage", int'(bus.sts_stage), 0);
    check("s4_abort_trg",   int'(bus.sts_trg),   0);
    cycle(1'b1, 1'b1, 1'b0, 4'b0000);
    check("s4_both_armed", int'(bus.sts_armed), 0);
    cycle(1'b0, 1'b0, 1'b1, 4'b0010);
    check("s4_idle_stage", int'(bus.sts_stage), 0);

    // Scenario 5: re-arm during delay with a new configuration
    t_lst = 0; t_sel[0] = 2; t_cnt[0] = 0; t_dly = 3;
    apply_cfg();
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b1, 4'b0100);
    cycle(1'b0, 1'b0, 1'b1, 4'b0000);
    t_sel[0] = 1; t_cnt[0] = 1; t_dly = 0;
    apply_cfg();
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    check("s5_rearm_armed", int'(bus.sts_armed), 1);
    check("s5_rearm_done",  int'(bus.sts_done),  0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 4'b0100);
      check($sformatf("s5_old%0d", k), int'(bus.sts_trg), 0);
    end
    cycle(1'b0, 1'b0, 1'b1, 4'b0010);
    check("s5_hit1", int'(bus.sts_trg), 0);
    cycle(1'b0, 1'b0, 1'b1, 4'b0010);
    check("s5_hit2", int'(bus.sts_trg), 1);

    // Scenario 6: asynchronous reset while armed with a hit pending
    t_lst = 0; t_sel[0] = 2; t_cnt[0] = 0; t_dly = 0;
    apply_cfg();
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    bus.ctl_arm      = 1'b0;
    bus.sti_transfer = 1'b1;
    bus.sti_evt      = 4'b0100;
    #2 rst = 1'b0;
    #1;
    check("s6_armed", int'(bus.sts_armed), 0);
    check("s6_trg",   int'(bus.sts_trg),   0);
    check("s6_done",  int'(bus.sts_done),  0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 4'b0100);
    check("s6_post_armed", int'(bus.sts_armed), 0);
    check("s6_post_done",  int'(bus.sts_done),  0);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        t_lst = int'($urandom_range(0, NS - 1));
        for (int k = 0; k < NS; k++) begin
          t_sel[k] = int'($urandom_range(0, NE - 1));
          t_cnt[k] = int'($urandom_range(0, 3));
        end
        t_dly = int'($urandom_range(0, 4));
        apply_cfg();
      end
      if (m_phase == 0 || m_phase == 3)
        bus.ctl_arm = ($urandom_range(0, 3) == 0);
      else
        bus.ctl_arm = ($urandom_range(0, 149) == 0);
      bus.ctl_abort    = ($urandom_range(0, 199) == 0);
      bus.sti_transfer = ($urandom_range(0, 99) < 60);
      bus.sti_evt      = NE'($urandom);
    end

    @(negedge clk);
    bus.ctl_arm      = 1'b0;
    bus.ctl_abort    = 1'b0;
    bus.sti_transfer = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Multi-stage trigger controller that sequences the outputs of up to NE `trigger_matcher` instances into a single capture trigger. Each stage waits for a selected matcher event to occur a configured number of times, then advances to the next stage. After the last stage, an optional post-trigger delay counts sample transfers before the block pulses the trigger. The block sits between the matcher bank and the capture/sampler control logic.

## Interface
Parameters:
- NS, 4, number of stages (power of two, ≥2)
- NE, 4, number of matcher event inputs (power of two, ≥2)
- CW, 16, hit/delay counter width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- ctl_arm  input  1  pulse: latch configuration, start at stage 0
- ctl_abort  input  1  pulse: return to IDLE
- cfg_sel  input  NS*log2(NE)  per-stage event index, stage k at slice k
- cfg_cnt  input  NS*CW  per-stage hit count minus one, stage k at slice k
- cfg_lst  input  log2(NS)  index of last active stage
- cfg_dly  input  CW  post-trigger delay in transfers
- sti_transfer  input  1  sample transfer qualifier (same stream the matchers see)
- sti_evt  input  NE  matcher `sts_evt` vector
- sts_armed  output  1  high in ARMED or DELAY
- sts_stage  output  log2(NS)  current stage index
- sts_trg  output  1  one-cycle trigger pulse
- sts_done  output  1  high in DONE

## Operation
- States: IDLE, ARMED, DELAY, DONE. Reset → IDLE. All outputs are 0 in reset.
- IDLE/DONE + ctl_arm: latch cfg_sel, cfg_cnt, cfg_lst, cfg_dly. Set stage=0, hit counter=0, then go to ARMED. Configuration inputs are ignored outside the arm cycle.
- ARMED: a hit is a cycle with sti_transfer=1 and sti_evt[sel[stage]]=1. Transfers without a hit hold the counter; the counter is cumulative and is not cleared by misses.
- On a hit with counter==cnt[stage]:
  - If stage<lst: stage+1, counter=0.
  - If stage==lst and dly==0: pulse sts_trg, go to DONE.
  - If stage==lst and dly>0: counter=0, go to DELAY.
- On any other hit: counter+1.
- DELAY: each transfer increments the counter. The transfer on which counter==dly-1 pulses sts_trg and moves the state to DONE, giving exactly dly transfers after the final hit.
- ctl_arm in ARMED/DELAY: restart, with the same actions as arming from IDLE.
- ctl_abort in any state: go to IDLE, clear stage and counter. No trg pulse is produced.
- ctl_abort and ctl_arm in the same cycle: abort wins.
- cfg_lst greater than NS-1 cannot occur because of the port width. Unused stages above lst are never visited.
- Counter arithmetic is unsigned CW bits. cnt=2^CW-1 requires 2^CW hits, and the counter does not wrap before its compare.

## Timing
- All state and outputs are registered.
- sts_trg is high for exactly the one cycle after the qualifying transfer edge.
- sts_done rises in the same cycle as sts_trg.
- Arm at edge t: ARMED and sts_armed=1 from t+1. A hit at t+1 is counted.
- sts_stage updates the cycle after the advancing hit.
- sti_evt is consumed as presented. Alignment with the matcher's registered output is the integrator's responsibility.
- Back-to-back hits on consecutive transfers are all counted, with no dead cycles.

## Configuration
- TRIGGER_SEQUENCER_DLY_EN defined: the DELAY state and the cfg_dly latch are present, and behaviour is as above.
- Not defined: DELAY is removed and cfg_dly is ignored. Trigger behaviour is identical to the dly==0 case.

## Structure
- Package `trigger_pkg`:
  - state enum typedef (IDLE, ARMED, DELAY, DONE)
  - stage-index and event-index width localparams derived from NS and NE
- Sub-module `trigger_counter`:
  - CW-bit counter with clear, enable and an equality-compare output
  - shared between hit counting and delay counting (one instance, reused by state)

## Test plan
- NS=4, lst=0, sel0=2, cnt0=0, dly=0; arm; pulse sti_evt[2] with a transfer → sts_trg one cycle later, sts_done=1, sts_armed=0.
- lst=2, cnt={0,3,1}, distinct sels; mixed miss/hit transfers → sts_stage steps 0→1 after 1 hit, 1→2 after 4 hits, trg after 2 further hits; misses and non-transfer cycles (event high, transfer low) do not count.
- lst=0, cnt0=0, dly=5, transfers gapped with idle cycles → trg exactly on the 5th transfer after the hit. With the macro undefined, trg follows the hit directly.
- Abort mid-stage 1 → IDLE next cycle, stage=0, no trg. Arm+abort in the same cycle → IDLE.
- Re-arm during DELAY with new cfg → counter and stage restart, the new cfg is used, and the old delay never fires.
- Assert rst (low) while ARMED with a hit pending → all outputs 0 immediately. After release the block stays IDLE until the next ctl_arm.
